matrix_mult_proc: RTL and testbench
===================================

# matrix_mult_proc

Fixed-size unsigned 8×8 matrix multiplier (C = A × B) with 8-bit elements and 16-bit results. It is a peripheral compute engine: operands arrive as flat 512-bit buses and the 1024-bit result bus is read by the surrounding bus-interface logic once `done` rises. One result element is produced per cycle using 8 parallel multipliers. A reuse option feeds the previous result back as an operand for chained products.

## Interface
- No parameters. Size is fixed: N = 8, element width 8, result width 16.
- `HCLK` input 1: single clock; all state changes on its rising edge.
- `HRESETn` input 1: asynchronous, active-high reset. Asserted when 1, despite the name.
- `start` input 1: level request, sampled only in IDLE.
- `reuse` input 2: `reuse[1]`=1 enables result feedback. `reuse[0]`=1 replaces A with the previous result; `reuse[0]`=0 replaces B with it.
- `A_data` input 512: element i at bits [8i+7:8i], row-major, i = row·8 + col.
- `B_data` input 512: same layout as `A_data`.
- `result` output 1024: element i at bits [16i+15:16i], row-major, registered.
- `done` output 1: high while the completed result is valid (DONE state).

## Operation
- States:
  - **IDLE**: default state after reset.
  - **CALC**: 64 cycles, one output element per cycle.
  - **DONE**: result complete.
- IDLE → CALC when `start`=1 at a rising edge. On that same edge:
  - Capture `A_data` and `B_data` into internal operand registers Ar and Br.
  - Clear element index k to 0.
- Reuse at capture:
  - `reuse`=2'b10: Br[i] ← low 8 bits of current `result[i]`; Ar from `A_data`.
  - `reuse`=2'b11: Ar[i] ← low 8 bits of current `result[i]`; Br from `B_data`.
  - `reuse[1]`=0: both operands come from the input buses.
- CALC, each edge:
  - r = k/8, c = k%8.
  - result[k] ← Σ_{j=0..7} Ar[r·8+j] · Br[j·8+c].
  - Then k ← k+1.
- Arithmetic is unsigned. Each product is 16 bits and the sum is formed at 19 bits. The result is truncated to the low 16 bits (mod 2^16), with no saturation.
- After the edge that writes k=63, the state goes to DONE.
- DONE:
  - `done`=1 and `result` is held constant.
  - Stay in DONE while `start`=1. Go to IDLE on the first edge with `start`=0.
  - A `start` held high therefore yields exactly one computation.
- `A_data`, `B_data` and `reuse` are ignored outside the capture edge. Changing them during CALC has no effect.
- `result` elements not yet written in CALC keep their previous values. `result` is only guaranteed coherent while `done`=1.

## Timing
- Reset (async, any state): state=IDLE, `done`=0, `result`=0, Ar=Br=0, k=0.
- Reset mid-CALC aborts the computation. The partial result is lost (cleared to 0).
- Latency: start-sampling edge E0, elements written at E1..E64, `done`=1 after E64. That is 64 cycles from the capture edge to `done`.
- `done` falls on the edge that leaves DONE, which is the first edge with `start`=0. The earliest re-capture is the following edge in IDLE.
- Minimum back-to-back period: 66 cycles (capture, 64 CALC, ≥1 DONE, ≥1 IDLE).
- `start` asserted during CALC or DONE is not a new request. No queuing.

## Test plan
- All A and B elements 0x01, `reuse`=00, `start` held high → all 64 results 0x0008; `done` rises 64 cycles after capture and stays high; no second run.
- A arbitrary (A[i] = i), B identity (0x01 on diagonal, else 0) → result[i] = i, zero-extended.
- All elements 0xFF → every result 0xF008 (520200 mod 65536).
- After the all-ones run, deassert `start`, set `reuse`=2'b11 with B all 0x01, reassert → Ar = 0x08 everywhere, all results 0x0040. Repeat with `reuse`=2'b10 and A all 0x01 → same 0x0040.
- Change `A_data` during CALC → result matches operands captured at E0.
- Assert `HRESETn` mid-CALC → `done`=0, `result`=0 immediately (asynchronously); after release, a new `start` produces a correct result 64 cycles later.

Source files
------------

// File: rtl/matrix_mult_proc.sv
// matrix_mult_proc: unsigned 8x8 matrix multiplier, C = A x B.
// Operands are 8-bit elements on flat 512-bit buses, results are 16-bit
// elements on a flat 1024-bit bus. One result element is produced per cycle
// from eight parallel multipliers. An optional feedback path substitutes the
// low byte of each previous result element for A or B when chaining products.
module matrix_mult_proc (
    input  logic          HCLK,
    input  logic          HRESETn,   // active-high despite the name
    input  logic          start,
    input  logic [1:0]    reuse,
    input  logic [511:0]  A_data,
    input  logic [511:0]  B_data,
    output logic [1023:0] result,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    k_q, k_d;
    logic [511:0]  ar_q, br_q;
    logic [1023:0] result_q;

    // Element views of the operand registers and the feedback bytes
    logic [7:0]    a_mat [64];
    logic [7:0]    b_mat [64];
    logic [511:0]  result_lo;

    logic [2:0]    row, col;
    logic [15:0]   prod [8];
    // The mathematical sum needs 19 bits, but only its low 16 bits are kept,
    // and modular addition at 16 bits yields exactly those bits.
    logic [15:0]   dot_sum;

    assign row = k_q[5:3];
    assign col = k_q[2:0];

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_elem
            assign a_mat[gi]               = ar_q[8*gi +: 8];
            assign b_mat[gi]               = br_q[8*gi +: 8];
            assign result_lo[8*gi +: 8]    = result_q[16*gi +: 8];
        end
        for (gi = 0; gi < 8; gi++) begin : g_mul
            localparam logic [2:0] J = 3'(gi);
            // Multiplier j: A[row][j] * B[j][col]
            assign prod[gi] = {8'd0, a_mat[{row, J}]} * {8'd0, b_mat[{J, col}]};
        end
    endgenerate

    // Adder tree for the current row/column dot product
    always_comb begin
        dot_sum = 16'd0;
        for (int j = 0; j < 8; j++) begin
            dot_sum = dot_sum + prod[j];
        end
    end

    // State register and element index
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            state_q <= ST_IDLE;
            k_q     <= 6'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Next-state logic: one pass per start, held in DONE until start drops
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    k_d     = 6'd0;
                end
            end
            ST_CALC: begin
                k_d = k_q + 6'd1;
                if (k_q == 6'd63) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = 6'd0;
            end
        endcase
    end

    // Operand capture (with optional feedback) and per-element result write
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            ar_q     <= '0;
            br_q     <= '0;
            result_q <= '0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                ar_q <= (reuse == 2'b11) ? result_lo : A_data;
                br_q <= (reuse == 2'b10) ? result_lo : B_data;
            end
            if (state_q == ST_CALC) begin
                result_q[{k_q, 4'b0000} +: 16] <= dot_sum;
            end
        end
    end

    assign result = result_q;
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_matrix_mult_proc.sv
// Directed bench for matrix_mult_proc: a table of operand/expected-result
// records run back to back (some depend on the previous result through the
// reuse path), followed by an asynchronous mid-computation reset sequence.
module tb_matrix_mult_proc;

    logic          HCLK;
    logic          HRESETn;
    logic          start;
    logic [1:0]    reuse;
    logic [511:0]  A_data;
    logic [511:0]  B_data;
    logic [1023:0] result;
    logic          done;

    int n_chk = 0;
    int n_err = 0;
    logic [1023:0] prev_exp;

    matrix_mult_proc dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .start   (start),
        .reuse   (reuse),
        .A_data  (A_data),
        .B_data  (B_data),
        .result  (result),
        .done    (done)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string          name;
        logic [511:0]   a;
        logic [511:0]   b;
        logic [1:0]     reuse;
        bit             perturb;
        logic [1023:0]  exp;
    } vec_t;

    function automatic logic [511:0] fill8(input logic [7:0] v);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = v;
        return r;
    endfunction

    function automatic logic [1023:0] fill16(input logic [15:0] v);
        logic [1023:0] r;
        for (int i = 0; i < 64; i++) r[16*i +: 16] = v;
        return r;
    endfunction

    function automatic logic [511:0] ramp8();
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = 8'(i);
        return r;
    endfunction

    function automatic logic [1023:0] ramp16();
        logic [1023:0] r;
        for (int i = 0; i < 64; i++) r[16*i +: 16] = 16'(i);
        return r;
    endfunction

    function automatic logic [511:0] ident8();
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = (i % 9 == 0) ? 8'h01 : 8'h00;
        return r;
    endfunction

    task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic check_res(input string nm, input logic [1023:0] req);
        n_chk++;
        if (result !== req) begin
            n_err++;
            for (int i = 0; i < 64; i++) begin
                if (result[16*i +: 16] !== req[16*i +: 16]) begin
                    $display("FAIL %s: element %0d got 0x%04h, expected 0x%04h",
                             nm, i, result[16*i +: 16], req[16*i +: 16]);
                    break;
                end
            end
        end
    endtask

    // Apply one vector starting at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_vec(input vec_t v);
        int   cyc;
        logic got_done;
        A_data = v.a;
        B_data = v.b;
        reuse  = v.reuse;
        start  = 1'b1;
        @(posedge HCLK);            // capture edge E0
        cyc      = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            @(posedge HCLK);
            #1;
            cyc++;
            if (cyc == 1) begin
                // Only element 0 has been written; element 1 still holds the old value
                check1({v.name, "_e1_elem0"}, 32'(result[15:0]), 32'(v.exp[15:0]));
                check1({v.name, "_e1_elem1_old"}, 32'(result[31:16]), 32'(prev_exp[31:16]));
            end
            if (v.perturb && cyc == 10) begin
                A_data = fill8(8'hFF);
                B_data = fill8(8'h00);
                reuse  = 2'b11;
            end
            got_done = done;
        end
        check1({v.name, "_latency"}, 32'(cyc), 32'd64);
        check_res({v.name, "_result"}, v.exp);
        $display("vec %-12s latency=%0d elem0=0x%04h elem63=0x%04h",
                 v.name, cyc, result[15:0], result[1023:1008]);
        // start held high in DONE: no new run, done stays high
        for (int h = 0; h < 3; h++) begin
            A_data = ~A_data;
            @(posedge HCLK);
            #1;
            check1({v.name, "_done_hold"}, 32'(done), 32'd1);
        end
        check_res({v.name, "_result_hold"}, v.exp);
        start = 1'b0;
        @(posedge HCLK);
        #1;
        check1({v.name, "_done_fall"}, 32'(done), 32'd0);
        prev_exp = v.exp;
        @(negedge HCLK);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{"ones",       fill8(8'h01), fill8(8'h01), 2'b00, 1'b0, fill16(16'h0008)};
        vecs[1] = '{"ramp_ident", ramp8(),      ident8(),     2'b00, 1'b0, ramp16()};
        vecs[2] = '{"all_ff",     fill8(8'hFF), fill8(8'hFF), 2'b00, 1'b0, fill16(16'hF008)};
        vecs[3] = '{"reuse_a",    fill8(8'h55), fill8(8'h01), 2'b11, 1'b0, fill16(16'h0040)};
        vecs[4] = '{"all_ff_2",   fill8(8'hFF), fill8(8'hFF), 2'b00, 1'b0, fill16(16'hF008)};
        vecs[5] = '{"reuse_b",    fill8(8'h01), fill8(8'hAA), 2'b10, 1'b0, fill16(16'h0040)};
        vecs[6] = '{"chain_b",    fill8(8'h01), fill8(8'hAA), 2'b10, 1'b0, fill16(16'h0200)};
        vecs[7] = '{"two_three",  fill8(8'h02), fill8(8'h03), 2'b00, 1'b0, fill16(16'h0030)};
        vecs[8] = '{"perturb",    ramp8(),      ident8(),     2'b00, 1'b1, ramp16()};

        HRESETn  = 1'b1;
        start    = 1'b0;
        reuse    = 2'b00;
        A_data   = '0;
        B_data   = '0;
        prev_exp = '0;
        #1;
        check1("reset_done", 32'(done), 32'd0);
        check_res("reset_result", '0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check1("idle_done", 32'(done), 32'd0);

        for (int v = 0; v < 9; v++) begin
            run_vec(vecs[v]);
        end

        // Asynchronous reset in the middle of a computation
        A_data = fill8(8'h01);
        B_data = fill8(8'h01);
        reuse  = 2'b00;
        start  = 1'b1;
        @(posedge HCLK);
        repeat (20) @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        #1;
        check1("midcalc_reset_done", 32'(done), 32'd0);
        check_res("midcalc_reset_result", '0);
        $display("reset mid-CALC applied done=%0b", done);
        start = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b0;
        @(negedge HCLK);
        prev_exp = '0;
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
